// File: rtl/i2c_master_wr.sv
// i2c_master_wr: write-only I2C bus master.
// Sends START, 7-bit address + W, a stream of data bytes taken over a
// valid/ready handshake (each followed by an ACK check), then STOP.
// Optional feature: define I2C_MASTER_STRETCH_EN to honour slave clock
// stretching (phase counter stalls while scl_in is held low in the SCL-high half).
// Without the macro scl_in is not used by any logic.
module i2c_master_wr #(
  parameter int SCL_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic [6:0] addr_in,
  input  logic [7:0] wdata_in,
  input  logic       wvalid_in,
  input  logic       last_in,
  output logic       wready_out,
  output logic       scl_out,
  output logic       sda_out,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       nack_out
);

  localparam int PW = $clog2(SCL_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK_A, S_WAIT, S_DATA, S_ACK_D, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [1:0]      quarter_q, quarter_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            nack_q, nack_d;

  logic            adv;
  logic            phase_end;
  logic            bit_end;
  logic            ack_sample;

`ifdef I2C_MASTER_STRETCH_EN
  // In the SCL-high half, a bus SCL held low by the slave freezes bit timing.
  assign adv = !(quarter_q[1] && !scl_in);
`else
  // Free-running timing; scl_in is deliberately left unconnected to logic.
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign adv = 1'b1;
`endif

  assign phase_end  = (phase_q == PW'(SCL_DIV - 1));
  assign bit_end    = adv && phase_end && (quarter_q == 2'd3);
  assign ack_sample = adv && (quarter_q == 2'd3) && (phase_q == '0);

  // State and datapath registers; reset releases both bus lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      nack_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      nack_q    <= nack_d;
    end
  end

  // Next-state, bit timing and byte shifting.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    nack_d    = nack_q;

    // Default quarter/phase advance; a stall restarts the SCL-high half.
    if (!adv) begin
      phase_d   = '0;
      quarter_d = 2'd2;
    end else if (phase_end) begin
      phase_d   = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      phase_d   = phase_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        phase_d   = '0;
        quarter_d = 2'd0;
        if (start_in) begin
          shift_d = {addr_in, 1'b0};
          nack_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = 3'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        if (bit_end) begin
          shift_d = {shift_q[6:0], 1'b0};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (state_q == S_ADDR) ? S_ACK_A : S_ACK_D;
          end
        end
      end
      S_ACK_A, S_ACK_D: begin
        if (ack_sample && sda_in) begin
          nack_d = 1'b1;
        end
        // nack_q is already valid here: the sample precedes the bit end.
        if (bit_end) begin
          if (nack_q || (state_q == S_ACK_D && last_q)) begin
            state_d = S_STOP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Counters hold at the start of the first data bit; this cycle
        // doubles as its first clock, so an immediate byte costs nothing.
        phase_d   = '0;
        quarter_d = 2'd0;
        if (wvalid_in) begin
          shift_d = wdata_in;
          last_d  = last_in;
          bit_d   = 3'd0;
          phase_d = PW'(1);
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Open-drain line drives decoded from state and quarter.
  always_comb begin
    scl_out = 1'b1;
    sda_out = 1'b1;
    case (state_q)
      S_IDLE:  begin scl_out = 1'b1;         sda_out = 1'b1; end
      S_START: begin scl_out = 1'b1;         sda_out = !quarter_q[1]; end
      S_ADDR,
      S_DATA:  begin scl_out = quarter_q[1]; sda_out = shift_q[7]; end
      S_ACK_A,
      S_ACK_D: begin scl_out = quarter_q[1]; sda_out = 1'b1; end
      S_WAIT:  begin scl_out = 1'b0;         sda_out = 1'b1; end
      S_STOP:  begin scl_out = quarter_q[1]; sda_out = (quarter_q == 2'd3); end
      default: begin scl_out = 1'b1;         sda_out = 1'b1; end
    endcase
  end

  assign wready_out = (state_q == S_WAIT);
  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign nack_out   = nack_q;

endmodule
